iomem_arbiter: RTL
==================

Name: iomem_arbiter

Overview:
- Shares the single 32-bit softcore memory port (valid/ready, 23-bit address, SDRAM/BSRAM behind it) among three requesters:
  - m0: firmware flash loader
  - m1: RV32 softcore
  - m2: ROM/savestate DMA engine
- Sits between the iosys requesters and the SDRAM controller's rv_* port, replacing the ad-hoc flash_loading mux.
- Grants one transaction at a time. Transactions are registered for timing. A watchdog guarantees forward progress.

Parameters:
- TIMEOUT, 1024: max cycles to wait for s_ready before aborting a transaction.
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on an aborted transaction.

Ports:
- clk  in  1  system clock (SNES mclk domain)
- reset  in  1  asynchronous, active-high reset
- mN_valid  in  1  request from master N (N=0,1,2); held high until mN_ready
- mN_addr  in  23  byte address
- mN_wdata  in  32  write data
- mN_wstrb  in  4  byte strobes; 0 = read
- mN_ready  out  1  one-cycle completion pulse
- mN_rdata  out  32  read data, valid while mN_ready=1
- s_valid  out  1  request to SDRAM port
- s_addr  out  23  latched address
- s_wdata  out  32  latched write data
- s_wstrb  out  4  latched strobes
- s_ready  in  1  completion pulse from SDRAM port
- s_rdata  in  32  read data, valid with s_ready
- grant_id  out  2  owner of current/last transaction (debug)
- timeout_err  out  1  sticky flag: a transaction was aborted

Behaviour:
- Reset (async, immediate): state=IDLE; all mN_ready=0, mN_rdata=0; s_valid=0, s_addr/s_wdata/s_wstrb=0; grant_id=0; rr_ptr=m1; timeout_err=0; wdog=0.
  - Reset mid-transaction abandons it; no ready is ever issued for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any mN_valid, select a winner:
    - m0 has absolute priority.
    - Otherwise round-robin between m1 and m2 using rr_ptr; if only one of them requests, it wins.
  - At the clock edge:
    - Latch the winner's addr/wdata/wstrb into s_*.
    - s_valid<=1, grant_id<=winner, wdog<=0, go BUSY.
    - If the winner is m1 or m2, rr_ptr<=the other one.
  - Latency: mN_valid sampled high in IDLE gives s_valid high the next cycle.
- BUSY:
  - s_valid stays high; s_* outputs are stable; wdog increments each cycle.
  - On s_ready=1:
    - Latch s_rdata into rdata_q, s_valid<=0, go DONE.
  - Else if wdog==TIMEOUT-1:
    - rdata_q<=ERR_RDATA, s_valid<=0, timeout_err<=1, go DONE.
  - If s_ready and timeout coincide, s_ready wins: real data, no error.
- DONE (exactly 1 cycle):
  - m[grant_id]_ready=1 and m[grant_id]_rdata=rdata_q; all other mN_ready=0.
  - Next state is IDLE.
  - Requesters drop valid on the edge that samples ready, so IDLE never re-grants a completed request.
- Minimum transaction: 3 cycles (IDLE→BUSY→DONE) plus SDRAM latency.
- Request inputs are ignored outside IDLE; losers simply keep valid high and wait.
- s_ready outside BUSY is ignored. This covers a late SDRAM response after a timeout.
- Writes also complete via DONE; mN_rdata is don't-care for writes but still driven from rdata_q.
- mN_rdata holds its last value when mN_ready=0.
- wdog width: $clog2(TIMEOUT)+1 bits, no wrap inside BUSY.
- timeout_err is cleared only by reset.

Decomposition:
- Shared package iosys_pkg:
  - state enum {IDLE, BUSY, DONE}
  - master-id constants M_FLASH=0, M_CPU=1, M_DMA=2
  - RV_AW=23, RV_DW=32
- One natural sub-module: iomem_rr_pick. Combinational fixed-priority + 2-way round-robin selector with inputs valid[2:0] and rr_ptr, outputs winner[1:0] and any.
- Latching, watchdog and FSM stay in iomem_arbiter.

Test Plan:
- Single read: m1_valid, addr=0x000100, wstrb=0; slave returns s_rdata=0xDEADBEEF after 4 cycles → s_valid/s_addr=0x000100 on cycle 1; m1_ready one pulse with rdata 0xDEADBEEF; m0/m2_ready stay 0.
- Priority: m0, m1, m2 valid in the same cycle → m0 granted first; then m1 and m2 alternate (m1, m2, m1...) when both stay requesting; m0 preempts at every IDLE in which it requests.
- Round-robin fairness: m1 and m2 continuously requesting 10 transactions each → grant_id sequence alternates 1,2,1,2; counts equal ±1.
- Write byte strobe: m0 write addr=0x000003, wstrb=4'b1000, wdata=0xAA000000 → s_* match exactly, s_wstrb=4'b1000; m0_ready after s_ready.
- Timeout: slave never asserts s_ready, TIMEOUT=16 → s_valid drops after 16 BUSY cycles; m1_ready with rdata 0xFFFFFFFF; timeout_err=1 and sticky. A later spurious s_ready is ignored and the next transaction works.
- Async reset mid-BUSY: assert reset between clock edges → s_valid, mN_ready and timeout_err fall to 0 immediately. After release, a pending m2 request is granted normally.

Source files
------------

// File: rtl/iosys_pkg.sv
// Shared definitions for the iosys memory-port arbiter.
//   state_t          : arbiter FSM states
//   M_FLASH/CPU/DMA  : requester ids as reported on grant_id
//   RV_AW / RV_DW    : address and data widths of the softcore memory port
package iosys_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] M_FLASH = 2'd0;
    localparam logic [1:0] M_CPU   = 2'd1;
    localparam logic [1:0] M_DMA   = 2'd2;

    localparam int NUM_M = 3;
    localparam int RV_AW = 23;
    localparam int RV_DW = 32;

endpackage

// File: rtl/iomem_arbiter_if.sv
// Valid/ready memory bus used on both sides of the arbiter.
//   master modport : drives valid/addr/wdata/wstrb, receives ready/rdata
//   slave  modport : receives a request, returns ready/rdata
// wstrb == 0 marks a read; ready is a single-cycle completion pulse.
interface iomem_arbiter_if;
    import iosys_pkg::*;

    logic             valid;
    logic [RV_AW-1:0] addr;
    logic [RV_DW-1:0] wdata;
    logic [3:0]       wstrb;
    logic             ready;
    logic [RV_DW-1:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
    modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);

endinterface

// File: rtl/iomem_rr_pick.sv
// Combinational winner selection for the arbiter.
//   valid[2:0] : per-requester request lines
//   rr_ptr     : which of M_CPU / M_DMA is preferred when both request
//   winner     : selected requester id (M_FLASH when nothing requests)
//   any        : at least one request present
// The flash loader always wins; CPU and DMA share the rest round-robin.
module iomem_rr_pick
    import iosys_pkg::*;
(
    input  logic [NUM_M-1:0] valid,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       winner,
    output logic             any
);

    always_comb begin
        winner = M_FLASH;
        if (valid[M_FLASH]) begin
            winner = M_FLASH;
        end else if (valid[M_CPU] && valid[M_DMA]) begin
            winner = (rr_ptr == M_DMA) ? M_DMA : M_CPU;
        end else if (valid[M_CPU]) begin
            winner = M_CPU;
        end else if (valid[M_DMA]) begin
            winner = M_DMA;
        end
    end

    assign any = |valid;

endmodule

// File: rtl/iomem_arbiter.sv
// Shares the single softcore memory port among three requesters
// (m0 flash loader, m1 RV32 core, m2 ROM/savestate DMA), one transaction
// at a time, with a watchdog that aborts a stalled slave.
//   clk, reset   : clock, asynchronous active-high reset
//   m0, m1, m2   : requester buses (slave modport)
//   s            : SDRAM/BSRAM port (master modport), request registered
//   grant_id     : owner of the current/last transaction
//   timeout_err  : sticky, set when a transaction was aborted
module iomem_arbiter
    import iosys_pkg::*;
#(
    parameter int               TIMEOUT   = 1024,
    parameter logic [RV_DW-1:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    iomem_arbiter_if.slave    m0,
    iomem_arbiter_if.slave    m1,
    iomem_arbiter_if.slave    m2,
    iomem_arbiter_if.master   s,
    output logic [1:0]        grant_id,
    output logic              timeout_err
);

    // One spare bit so the counter can never wrap while in BUSY.
    localparam int WD_W = $clog2(TIMEOUT) + 1;

    logic [NUM_M-1:0] req_valid;
    logic [RV_AW-1:0] req_addr  [NUM_M];
    logic [RV_DW-1:0] req_wdata [NUM_M];
    logic [3:0]       req_wstrb [NUM_M];

    assign req_valid    = {m2.valid, m1.valid, m0.valid};
    assign req_addr[0]  = m0.addr;
    assign req_addr[1]  = m1.addr;
    assign req_addr[2]  = m2.addr;
    assign req_wdata[0] = m0.wdata;
    assign req_wdata[1] = m1.wdata;
    assign req_wdata[2] = m2.wdata;
    assign req_wstrb[0] = m0.wstrb;
    assign req_wstrb[1] = m1.wstrb;
    assign req_wstrb[2] = m2.wstrb;

    state_t           state_q;
    logic [1:0]       rr_ptr_q;
    logic [1:0]       grant_q;
    logic [WD_W-1:0]  wdog_q;
    logic             s_valid_q;
    logic [RV_AW-1:0] s_addr_q;
    logic [RV_DW-1:0] s_wdata_q;
    logic [3:0]       s_wstrb_q;
    logic             timeout_err_q;
    logic [NUM_M-1:0] ready_q;

    logic [1:0] winner;
    logic       any_req;

    iomem_rr_pick u_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr_q),
        .winner (winner),
        .any    (any_req)
    );

    logic wdog_expired;
    logic busy_end;
    logic [RV_DW-1:0] end_data;

    assign wdog_expired = (wdog_q == WD_W'(TIMEOUT - 1));
    // A slave response in the final watchdog cycle still counts as success.
    assign busy_end     = (state_q == BUSY) && (s.ready || wdog_expired);
    assign end_data     = s.ready ? s.rdata : ERR_RDATA;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= M_CPU;
            grant_q       <= M_FLASH;
            wdog_q        <= '0;
            s_valid_q     <= 1'b0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            s_wstrb_q     <= '0;
            timeout_err_q <= 1'b0;
            ready_q       <= '0;
        end else begin
            ready_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        s_addr_q  <= req_addr[winner];
                        s_wdata_q <= req_wdata[winner];
                        s_wstrb_q <= req_wstrb[winner];
                        s_valid_q <= 1'b1;
                        grant_q   <= winner;
                        wdog_q    <= '0;
                        state_q   <= BUSY;
                        if (winner == M_CPU) begin
                            rr_ptr_q <= M_DMA;
                        end else if (winner == M_DMA) begin
                            rr_ptr_q <= M_CPU;
                        end
                    end
                end
                BUSY: begin
                    wdog_q <= wdog_q + WD_W'(1);
                    if (busy_end) begin
                        s_valid_q        <= 1'b0;
                        ready_q[grant_q] <= 1'b1;
                        state_q          <= DONE;
                        if (!s.ready) begin
                            timeout_err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Per-requester read data: only the owner's register is updated, so
    // every other requester keeps its last returned word.
    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_rd
        logic [RV_DW-1:0] rdata_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                rdata_q <= '0;
            end else if (busy_end && (grant_q == 2'(gi))) begin
                rdata_q <= end_data;
            end
        end
    end

    assign m0.ready = ready_q[0];
    assign m1.ready = ready_q[1];
    assign m2.ready = ready_q[2];
    assign m0.rdata = g_rd[0].rdata_q;
    assign m1.rdata = g_rd[1].rdata_q;
    assign m2.rdata = g_rd[2].rdata_q;

    assign s.valid     = s_valid_q;
    assign s.addr      = s_addr_q;
    assign s.wdata     = s_wdata_q;
    assign s.wstrb     = s_wstrb_q;
    assign grant_id    = grant_q;
    assign timeout_err = timeout_err_q;

endmodule
